// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and default operand width for the shift-add multiplier
package mult_pkg;
    localparam int DEFAULT_WIDTH = 4;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: request/result bundle between a requester and the multiplier
interface shift_add_multiplier_if import mult_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   X;
    logic [WIDTH-1:0]   Y;
    logic [2*WIDTH-1:0] Z;
    logic               busy;
    logic               done;
    modport master (output start, signed_mode, X, Y, input Z, busy, done);
    modport slave (input start, signed_mode, X, Y, output Z, busy, done);
endinterface

// File: rtl/mult_datapath.sv
// mult_datapath: accumulator, operand shifters and signed MSB correction for shift-add multiply
module mult_datapath #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               last,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] product
);
    logic [2*WIDTH-1:0] mcand, acc, term;
    logic [WIDTH-1:0]   mplier;
    logic               sgn;
    // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so its partial product is subtracted
    always_comb begin
        term    = mplier[0] ? mcand : '0;
        product = (last && sgn) ? acc - term : acc + term;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            sgn    <= 1'b0;
        end else if (load) begin
            mcand  <= signed_mode ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
            mplier <= y;
            acc    <= '0;
            sgn    <= signed_mode;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential WIDTH-cycle shift-add multiplier with IDLE/CALC/DONE control
module shift_add_multiplier import mult_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic               clock_100Mhz,
    input logic               reset,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] z, product;
    logic               accept, step, last;
    always_comb begin
        accept    = state == IDLE && bus.start;
        step      = state == CALC;
        last      = cnt == '0;
        state_nxt = state == IDLE ? (bus.start ? CALC : IDLE) :
                    state == CALC ? (last ? DONE : CALC) : IDLE;
    end
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            z     <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= CW'(WIDTH - 1);
            else if (step && !last)
                cnt <= cnt - CW'(1);
            if (step && last)
                z <= product;
        end
    end
    mult_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk(clock_100Mhz),
        .rst(reset),
        .load(accept),
        .step(step),
        .last(last),
        .signed_mode(bus.signed_mode),
        .x(bus.X),
        .y(bus.Y),
        .product(product)
    );
    assign bus.Z    = z;
    assign bus.busy = state == CALC;
    assign bus.done = state == DONE;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: randomized scoreboard bench for shift_add_multiplier (WIDTH=4)
module tb_shift_add_multiplier;
    localparam int W = 4;

    typedef struct {
        logic [2*W-1:0] z;
        int             due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    shift_add_multiplier_if #(.WIDTH(W)) bus();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clock_100Mhz(clk),
        .reset(reset),
        .bus(bus)
    );

    exp_t           sb[$];
    int             n_cmp = 0;
    int             n_fail = 0;
    int             cyc = 0;
    int             done_cnt = 0;
    logic [2*W-1:0] prev_z = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: exact integer product, truncated to 2*W bits
    function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        int p;
        if (s)
            p = int'($signed(x)) * int'($signed(y));
        else
            p = int'(x) * int'(y);
        return p[2*W-1:0];
    endfunction

    task automatic push(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input int extra);
        exp_t e;
        e.z   = model(s, x, y);
        e.due = cyc + 1 + W + extra;
        sb.push_back(e);
    endtask

    task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input bit acc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.signed_mode = s;
        bus.X = x;
        bus.Y = y;
        if (acc) push(s, x, y, 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.signed_mode = 1'($urandom);
        bus.X = W'($urandom);
        bus.Y = W'($urandom);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic rst_s;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            rst_s = reset;
            #1;
            if (rst_s) begin
                chk("reset_z", 32'(bus.Z), 0);
                chk("reset_done", 32'(bus.done), 0);
            end else if (bus.done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 0);
                end else begin
                    e = sb.pop_front();
                    chk("product", 32'(bus.Z), 32'(e.z));
                    chk("latency", cyc, e.due);
                    chk("busy_in_done", 32'(bus.busy), 0);
                end
            end else begin
                chk("z_hold", 32'(bus.Z), 32'(prev_z));
            end
            prev_z = bus.Z;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, dc, d0;
        bus.start = 1'b0;
        bus.signed_mode = 1'b0;
        bus.X = '0;
        bus.Y = '0;
        repeat (3) @(negedge clk);
        chk("rst_z", 32'(bus.Z), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);

        // First start accepted on the first edge with reset low; 15*15 unsigned
        reset = 1'b0;
        bus.start = 1'b1;
        bus.X = 4'd15;
        bus.Y = 4'd15;
        push(1'b0, 4'd15, 4'd15, 0);
        @(negedge clk);
        bus.start = 1'b0;
        bc = 0;
        dc = 0;
        for (int i = 0; i < 8; i++) begin
            bc += int'(bus.busy);
            dc += int'(bus.done);
            @(negedge clk);
        end
        chk("busy_cycles", bc, W);
        chk("done_cycles", dc, 1);
        chk("z_e1", 32'(bus.Z), 32'h e1);
        wait_idle();

        issue(1'b1, 4'h8, 4'h7, 1);
        wait_idle();
        chk("z_c8", 32'(bus.Z), 32'h c8);
        issue(1'b1, 4'h8, 4'h8, 1);
        wait_idle();
        chk("z_40", 32'(bus.Z), 32'h 40);

        // Second start during CALC is dropped
        d0 = done_cnt;
        issue(1'b0, 4'd3, 4'd5, 1);
        issue(1'b0, 4'd9, 4'd9, 0);
        wait_idle();
        repeat (8) @(negedge clk);
        chk("single_done", done_cnt - d0, 1);
        chk("z_0f", 32'(bus.Z), 32'h 0f);

        // Reset mid-CALC aborts without a done pulse
        d0 = done_cnt;
        issue(1'b0, 4'd5, 4'd7, 1);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_z", 32'(bus.Z), 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        issue(1'b0, 4'd2, 4'd6, 1);
        wait_idle();
        chk("z_0c", 32'(bus.Z), 32'h 0c);

        // start held high: one result every W+2 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.signed_mode = 1'b0;
        bus.X = 4'd0;
        bus.Y = 4'd13;
        push(1'b0, 4'd0, 4'd13, 0);
        push(1'b0, 4'd13, 4'd13, W + 2);
        @(negedge clk);
        bus.X = 4'd13;
        repeat (W + 3) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        chk("z_a9", 32'(bus.Z), 32'h a9);

        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), W'($urandom), W'($urandom), 1);
            if ($urandom_range(1, 0) == 1) begin
                @(negedge clk);
                bus.start = 1'b1;
                bus.X = W'($urandom);
                bus.Y = W'($urandom);
                @(negedge clk);
                bus.start = 1'b0;
            end
            wait_idle();
        end
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits; legal range 2..16.
REQ-002 Port: clock_100Mhz  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a multiply; sampled only while the block is idle.
REQ-005 Port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port: X  input  WIDTH  multiplicand; sampled with start.
REQ-007 Port: Y  input  WIDTH  multiplier; sampled with start.
REQ-008 Port: Z  output  2*WIDTH  registered product; holds the last completed result.
REQ-009 Port: busy  output  1  high from the accepting edge until the edge that enters DONE.
REQ-010 Port: done  output  1  one-cycle pulse; Z is valid and new while it is high.
REQ-011 One clock, clock_100Mhz; reset is synchronous and active-high.

Function
REQ-012 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-013 IDLE->CALC on an edge with start=1: capture X, Y and signed_mode, clear the accumulator, load the step counter with WIDTH-1.
REQ-014 CALC SHALL perform one shift-add step per cycle for exactly WIDTH cycles, then move to DONE.
REQ-015 On the CALC->DONE edge, Z SHALL be loaded with the full 2*WIDTH-bit product.
REQ-016 DONE->IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-017 Latency: start sampled at edge N -> done high in the cycle after edge N+WIDTH; Z updates at edge N+WIDTH.
REQ-018 busy=1 exactly in CALC.
REQ-019 start in CALC or DONE SHALL be ignored, with no queuing; operand changes during CALC SHALL not affect the result.
REQ-020 start held high continuously SHALL produce one result every WIDTH+2 cycles.
REQ-021 Unsigned mode: Z = X*Y, exact; no overflow is possible in 2*WIDTH bits.
REQ-022 Signed mode: Z = two's-complement X*Y, exact; this includes the most-negative-times-most-negative case.
REQ-023 Z SHALL hold its value in all states except on the CALC->DONE edge.

Reset
REQ-024 While reset=1 at an edge: state=IDLE, Z=0, busy=0, done=0, and accumulator, operand registers and counter cleared.
REQ-025 Reset SHALL take priority over start at the same edge.
REQ-026 Reset during CALC or DONE SHALL abort the operation: no done pulse is produced, and Z becomes 0.
REQ-027 The first start SHALL be accepted at the first edge with reset=0 and start=1.

Structure
REQ-028 A shared package mult_pkg SHALL hold the state typedef (IDLE/CALC/DONE) and the default-width constant.
REQ-029 The datapath SHALL be one sub-module, mult_datapath: accumulator, shifter and sign correction, parametrised by WIDTH.
REQ-030 The FSM and output registers SHALL be in shift_add_multiplier.
REQ-031 The block SHALL contain no combinational path from any input to any output.

Verification (WIDTH=4)
REQ-032 Unsigned, X=15, Y=15, start pulse at edge N -> Z=0xE1 with done high for exactly one cycle after edge N+4; busy high for 4 cycles.
REQ-033 Signed, X=-8 (0x8), Y=7 -> Z=0xC8; signed, X=-8, Y=-8 -> Z=0x40.
REQ-034 Start X=3, Y=5, then start again at N+2 with X=9, Y=9 -> only Z=0x0F is produced; the second request is dropped, and done pulses exactly once.
REQ-035 Reset asserted at N+2 during CALC -> busy=0, done never pulses, Z=0x00; a subsequent start with X=2, Y=6 -> Z=0x0C.
REQ-036 start held high, unsigned, X=0 then X=13, Y=13 -> Z=0x00 then Z=0xA9, done pulses 6 cycles apart.
